// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: FSM states, round count
// and the key-schedule round constants.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, KEY, RUN, DONE} ctrlState_t;

   localparam int NR_AES128 = 10;

   // Entry 0 and entries past round 10 are zero so any 4-bit index is safe.
   localparam logic [7:0] RCON_TABLE [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      return RCON_TABLE[rnd];
   endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-side bus of the AES round controller; the slave
// modport is the controller, the master modport is its environment.
interface aes_round_ctrl_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [127:0] rnd_data;
   logic [127:0] rnd_key;
   logic         rnd_last;
   logic [127:0] rnd_result;
   logic [7:0]   ks_rcon;
   logic [127:0] ks_next;
   logic         busy;

   modport master (
      output in_valid, in_data, in_key, out_ready, rnd_result, ks_next,
      input  in_ready, out_valid, out_data, rnd_data, rnd_key, rnd_last, ks_rcon, busy
   );

   modport slave (
      input  in_valid, in_data, in_key, out_ready, rnd_result, ks_next,
      output in_ready, out_valid, out_data, rnd_data, rnd_key, rnd_last, ks_rcon, busy
   );

endinterface

// File: rtl/aes_round_ctrl.sv
// Sequences NR AES-128 rounds through an external round datapath and
// key-expansion unit, one round key derived per KEY cycle.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR        = NR_AES128,
   parameter int ROUND_LAT = 3
) (
   input logic             clk,
   input logic             rst,
   aes_round_ctrl_if.slave bus
);

   localparam logic [3:0] LAST_RND = 4'(NR);
   localparam logic [3:0] LAST_CNT = 4'(ROUND_LAT);

   ctrlState_t   r_state;
   logic [3:0]   r_rnd;
   logic [3:0]   r_cnt;
   logic [127:0] r_data;
   logic [127:0] r_key;
   logic         r_inReady;
   logic         r_outValid;
   logic         r_busy;
   logic         r_rndLast;
   logic [7:0]   r_rcon;

   // Flag outputs are set on the edge that enters a state so they are
   // valid for that state's whole duration.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rnd      <= 4'd0;
         r_cnt      <= 4'd0;
         r_data     <= '0;
         r_key      <= '0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
         r_rndLast  <= 1'b0;
         r_rcon     <= 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_data    <= bus.in_data ^ bus.in_key;
                  r_key     <= bus.in_key;
                  r_rnd     <= 4'd1;
                  r_state   <= KEY;
                  r_inReady <= 1'b0;
                  r_busy    <= 1'b1;
                  r_rcon    <= rcon(4'd1);
                  r_rndLast <= (LAST_RND == 4'd1);
               end
            end
            KEY: begin
               r_key   <= bus.ks_next;
               r_cnt   <= 4'd0;
               r_rcon  <= 8'h00;
               r_state <= RUN;
            end
            RUN: begin
               if (r_cnt == LAST_CNT) begin
                  r_data <= bus.rnd_result;
                  if (r_rnd == LAST_RND) begin
                     r_state    <= DONE;
                     r_outValid <= 1'b1;
                     r_rndLast  <= 1'b0;
                  end else begin
                     r_rnd     <= r_rnd + 4'd1;
                     r_state   <= KEY;
                     r_rcon    <= rcon(r_rnd + 4'd1);
                     r_rndLast <= ((r_rnd + 4'd1) == LAST_RND);
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_busy     <= 1'b0;
                  r_rnd      <= 4'd0;
                  r_cnt      <= 4'd0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.busy      = r_busy;
   assign bus.rnd_last  = r_rndLast;
   assign bus.ks_rcon   = r_rcon;
   assign bus.out_data  = r_data;
   assign bus.rnd_data  = r_data;
   assign bus.rnd_key   = r_key;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: two builds (ROUND_LAT 3 and 1) driven by a
// behavioural AES round pipeline and key-expansion model.
module tb_aes_round_ctrl;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_round_ctrl_if busA();
   aes_round_ctrl_if busB();

   aes_round_ctrl #(.NR(10), .ROUND_LAT(3)) dutA (.clk(clk), .rst(rst), .bus(busA));
   aes_round_ctrl #(.NR(10), .ROUND_LAT(1)) dutB (.clk(clk), .rst(rst), .bus(busB));

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0]   sbox [256];
   logic [7:0]   rconSeen [$];
   int           lastFirst;
   int           lastCount;
   logic [127:0] snapState1, snapKey1, snapState2;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from the GF(2^8) inverse (v^254) followed by the affine transform.
   function automatic logic [7:0] sboxCalc(input logic [7:0] v);
      logic [7:0] inv;
      inv = 8'h00;
      if (v != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, v);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
      logic [7:0] sb [16];
      logic [7:0] sr [16];
      logic [7:0] mc [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) sb[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c + r] = sb[4*((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c + 1];
         a2 = sr[4*c + 2];
         a3 = sr[4*c + 3];
         if (last) begin
            mc[4*c]     = a0;
            mc[4*c + 1] = a1;
            mc[4*c + 2] = a2;
            mc[4*c + 3] = a3;
         end else begin
            mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = mc[i] ^ k[127-8*i -: 8];
      return res;
   endfunction

   function automatic logic [127:0] keyExpand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Round datapath models: ROUND_LAT register stages after the combinational round.
   logic [127:0] pipeA [3];
   logic [127:0] pipeB;

   always @(posedge clk) begin
      pipeA[0] <= aesRound(busA.rnd_data, busA.rnd_key, busA.rnd_last);
      pipeA[1] <= pipeA[0];
      pipeA[2] <= pipeA[1];
      pipeB    <= aesRound(busB.rnd_data, busB.rnd_key, busB.rnd_last);
   end

   assign busA.rnd_result = pipeA[2];
   assign busB.rnd_result = pipeB;
   assign busA.ks_next    = keyExpand(busA.rnd_key, busA.ks_rcon);
   assign busB.ks_next    = keyExpand(busB.rnd_key, busB.ks_rcon);

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key);
      checkOutput("accept_ready", 128'(busA.in_ready), 128'd1);
      busA.in_data  = pt;
      busA.in_key   = key;
      busA.in_valid = 1'b1;
      @(posedge clk);
      #1;
      busA.in_valid = 1'b0;
   endtask

   // Counts edges from the accepting edge until out_valid, recording the
   // round constants, last-round window and a few early round values.
   task automatic waitDone(input int injectAt, output int n);
      n = 0;
      rconSeen.delete();
      lastFirst = -1;
      lastCount = 0;
      while (1) begin
         if (busA.ks_rcon != 8'h00) rconSeen.push_back(busA.ks_rcon);
         if (busA.rnd_last) begin
            if (lastFirst < 0) lastFirst = n;
            lastCount++;
         end
         if (n == 0) snapState1 = busA.rnd_data;
         if (n == 1) snapKey1 = busA.rnd_key;
         if (n == 5) snapState2 = busA.rnd_data;
         if (busA.out_valid || n >= 200) break;
         if (n == injectAt) begin
            busA.in_data  = B_PT;
            busA.in_key   = B_KEY;
            busA.in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      logic [7:0] rconExp [10];
      int lat, bad, n;
      rconExp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      for (int v = 0; v < 256; v++) sbox[v] = sboxCalc(8'(v));

      rst = 1'b1;
      busA.in_valid = 1'b1;
      busA.in_data = FIPS_PT;
      busA.in_key = FIPS_KEY;
      busA.out_ready = 1'b1;
      busB.in_valid = 1'b0;
      busB.in_data = '0;
      busB.in_key = '0;
      busB.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 128'(busA.in_ready), 128'd1);
      checkOutput("rst_out_valid", 128'(busA.out_valid), 128'd0);
      checkOutput("rst_busy_over_hs", 128'(busA.busy), 128'd0);
      checkOutput("rst_rnd_last", 128'(busA.rnd_last), 128'd0);
      checkOutput("rst_ks_rcon", 128'(busA.ks_rcon), 128'd0);
      checkOutput("rst_out_data", busA.out_data, 128'd0);
      checkOutput("rst_rnd_data", busA.rnd_data, 128'd0);
      checkOutput("rst_rnd_key", busA.rnd_key, 128'd0);
      busA.in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] FIPS-197 C.1 block, out_ready held high");
      applyStimulus(FIPS_PT, FIPS_KEY);
      waitDone(-1, lat);
      checkOutput("c1_latency", 128'(lat), 128'd50);
      checkOutput("c1_ct", busA.out_data, FIPS_CT);
      checkOutput("c1_done_in_ready", 128'(busA.in_ready), 128'd0);
      checkOutput("c1_round1_start", snapState1, 128'h00102030405060708090a0b0c0d0e0f0);
      checkOutput("c1_round1_key", snapKey1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      checkOutput("c1_round2_start", snapState2, 128'h89d810e8855ace682d1843d8cb128fe4);
      checkOutput("c1_rcon_count", 128'(rconSeen.size()), 128'd10);
      for (int i = 0; i < 10 && i < rconSeen.size(); i++)
         checkOutput($sformatf("c1_rcon%0d", i + 1), 128'(rconSeen[i]), 128'(rconExp[i]));
      checkOutput("c1_last_first", 128'(lastFirst), 128'd45);
      checkOutput("c1_last_count", 128'(lastCount), 128'd5);
      @(posedge clk);
      #1;
      checkOutput("c1_idle_out_valid", 128'(busA.out_valid), 128'd0);
      checkOutput("c1_idle_in_ready", 128'(busA.in_ready), 128'd1);
      checkOutput("c1_idle_busy", 128'(busA.busy), 128'd0);

      $display("[TB] backpressure: out_ready low for 20 cycles");
      busA.out_ready = 1'b0;
      applyStimulus(FIPS_PT, FIPS_KEY);
      waitDone(-1, lat);
      checkOutput("bp_latency", 128'(lat), 128'd50);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (busA.out_valid !== 1'b1 || busA.out_data !== FIPS_CT || busA.in_ready !== 1'b0)
            bad++;
         @(posedge clk);
         #1;
      end
      checkOutput("bp_hold_violations", 128'(bad), 128'd0);
      busA.out_ready = 1'b1;
      checkOutput("bp_hs_in_ready", 128'(busA.in_ready), 128'd0);
      checkOutput("bp_hs_out_valid", 128'(busA.out_valid), 128'd1);
      @(posedge clk);
      #1;
      checkOutput("bp_after_in_ready", 128'(busA.in_ready), 128'd1);
      checkOutput("bp_after_out_valid", 128'(busA.out_valid), 128'd0);

      $display("[TB] second block offered during round 4");
      applyStimulus(FIPS_PT, FIPS_KEY);
      waitDone(16, lat);
      checkOutput("ign_latency", 128'(lat), 128'd50);
      checkOutput("ign_ct", busA.out_data, FIPS_CT);
      @(posedge clk);
      #1;
      checkOutput("ign_idle_in_ready", 128'(busA.in_ready), 128'd1);
      checkOutput("ign_idle_busy", 128'(busA.busy), 128'd0);
      applyStimulus(B_PT, B_KEY);
      checkOutput("ign_b_busy", 128'(busA.busy), 128'd1);
      checkOutput("ign_b_round1_start", busA.rnd_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      waitDone(-1, lat);
      checkOutput("ign_b_latency", 128'(lat), 128'd50);
      checkOutput("ign_b_ct", busA.out_data, B_CT);
      @(posedge clk);
      #1;

      $display("[TB] reset pulse during round 5");
      applyStimulus(FIPS_PT, FIPS_KEY);
      repeat (22) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("mid_rst_in_ready", 128'(busA.in_ready), 128'd1);
      checkOutput("mid_rst_busy", 128'(busA.busy), 128'd0);
      checkOutput("mid_rst_rnd_last", 128'(busA.rnd_last), 128'd0);
      checkOutput("mid_rst_out_data", busA.out_data, 128'd0);
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         if (busA.out_valid !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      checkOutput("mid_rst_no_out_valid", 128'(bad), 128'd0);
      applyStimulus(FIPS_PT, FIPS_KEY);
      waitDone(-1, lat);
      checkOutput("mid_rst_fresh_latency", 128'(lat), 128'd50);
      checkOutput("mid_rst_fresh_ct", busA.out_data, FIPS_CT);
      @(posedge clk);
      #1;

      $display("[TB] ROUND_LAT=1 build, FIPS-197 C.1 block");
      checkOutput("lat1_accept_ready", 128'(busB.in_ready), 128'd1);
      busB.in_data  = FIPS_PT;
      busB.in_key   = FIPS_KEY;
      busB.in_valid = 1'b1;
      @(posedge clk);
      #1;
      busB.in_valid = 1'b0;
      n = 0;
      while (busB.out_valid !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("lat1_latency", 128'(n), 128'd30);
      checkOutput("lat1_ct", busB.out_data, FIPS_CT);
      @(posedge clk);
      #1;
      checkOutput("lat1_idle_in_ready", 128'(busB.in_ready), 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds.
REQ-002 SHALL have parameter ROUND_LAT, default 3, legal range 1..15: edges from rnd_data/rnd_key presentation to valid rnd_result.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  plaintext/key offered.
REQ-006 SHALL have port in_ready  output  1  controller can accept.
REQ-007 SHALL have ports in_data  input  128  plaintext, and in_key  input  128  cipher key.
REQ-008 SHALL have port out_valid  output  1  ciphertext available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-010 SHALL have port out_data  output  128  ciphertext.
REQ-011 SHALL have port rnd_data  output  128  state fed to the shared round datapath.
REQ-012 SHALL have port rnd_key  output  128  round key fed to the round datapath.
REQ-013 SHALL have port rnd_last  output  1  selects the last-round path (no MixColumns).
REQ-014 SHALL have port rnd_result  input  128  round datapath output.
REQ-015 SHALL have ports ks_rcon  output  8  round constant, and ks_next  input  128  combinational next key from the key-expansion unit.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, KEY, RUN and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, state_reg<=in_data^in_key, key_reg<=in_key, rnd<=1, go to KEY.
REQ-019 KEY (1 cycle): ks_rcon=RCON[rnd]; key_reg<=ks_next; cnt<=0; go to RUN.
REQ-020 RUN: hold rnd_data=state_reg and rnd_key=key_reg stable for all ROUND_LAT+1 cycles; cnt increments each cycle.
REQ-021 RUN, cnt==ROUND_LAT: state_reg<=rnd_result; if rnd==NR go to DONE, else rnd<=rnd+1 and go to KEY.
REQ-022 rnd_last SHALL equal (rnd==NR) in KEY and RUN, and 0 otherwise.
REQ-023 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex); ks_rcon=00 outside KEY.
REQ-024 Each round SHALL take ROUND_LAT+2 cycles; out_valid SHALL rise exactly NR*(ROUND_LAT+2) edges after the accepting edge (50 at defaults).
REQ-025 DONE: out_valid=1, out_data=state_reg, both held stable until out_ready; on out_valid&out_ready go to IDLE.
REQ-026 in_ready SHALL be 0 in DONE, including the handshake cycle; the next accept occurs no earlier than the cycle after return to IDLE.
REQ-027 in_valid outside IDLE SHALL be ignored, with no state change.
REQ-028 out_ready outside DONE SHALL be ignored.
REQ-029 out_data SHALL equal state_reg in every state; consumers SHALL only sample it when out_valid=1.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, rnd=0, cnt=0, state_reg=0, key_reg=0.
REQ-031 Reset outputs: in_ready=1, out_valid=0, busy=0, rnd_last=0, ks_rcon=00, out_data=0, rnd_data=0, rnd_key=0.
REQ-032 rst asserted mid-operation SHALL discard the block in progress with no out_valid pulse; rst SHALL dominate any simultaneous handshake.

Structure
REQ-033 Package aes_pkg SHALL hold the FSM state enum, NR_AES128=10, the RCON table and an rcon(rnd) function.
REQ-034 The round counter and the wait counter SHALL be 4 bits each; no sub-module SHALL be instantiated, with RCON taken from aes_pkg.
REQ-035 The round and key-expansion datapaths SHALL stay outside this block; the bench SHALL bind a ROUND_LAT-stage round model and key-expansion model.

Verification
REQ-036 FIPS-197 C.1: key 000102..0f, pt 00112233..ff, out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 50 edges after accept.
REQ-037 ks_rcon during the 10 KEY cycles -> 01,02,04,08,10,20,40,80,1B,36 in order; rnd_last=1 only during round 10.
REQ-038 out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable for 20 cycles, in_ready=0 throughout; accept on cycle 21, in_ready=1 the next cycle.
REQ-039 in_valid=1 with a second block during round 4 -> ignored; first block's ciphertext correct; second block accepted only after return to IDLE.
REQ-040 rst pulse during round 5 -> next cycle in_ready=1, busy=0; no out_valid; a fresh FIPS block then completes correctly.
REQ-041 ROUND_LAT=1 build, same FIPS vector -> identical ciphertext, out_valid 30 edges after accept.
